// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
//   rxc_state_e             : receive-controller state encoding (2 bits, all codes used)
//   RXC_TIMEOUT_CYC_DEFAULT : default idle-timeout length in clk cycles
package uart_pkg;

    typedef enum logic [1:0] {
        RXC_DISABLED = 2'b00,
        RXC_LISTEN   = 2'b01,
        RXC_ACTIVE   = 2'b10,
        RXC_STOPPING = 2'b11
    } rxc_state_e;

    localparam logic [15:0] RXC_TIMEOUT_CYC_DEFAULT = 16'd1000;

endpackage

// File: rtl/uart_fifo.sv
// Generic first-word-fall-through byte FIFO with synchronous flush.
//   clk, rst  : clock, asynchronous active-low reset
//   flush     : clears pointers and level; same-cycle write/read discarded
//   wr_en     : write wr_data at the tail (ignored when full unless a pop happens too)
//   rd_en     : pop the head (ignored when empty)
//   rd_data   : head byte, valid while !empty
//   empty/full/level : occupancy status, level counts 0..DEPTH
module uart_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;

    logic [7:0] mem_q [DEPTH];
    ptr_t       wr_ptr_q;
    ptr_t       rd_ptr_q;
    lvl_t       level_q;
    logic       do_rd;
    logic       do_wr;

    assign empty   = (level_q == lvl_t'(0));
    assign full    = (level_q == lvl_t'(DEPTH));
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A pop frees the slot the write needs, so a full FIFO still accepts it.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + ptr_t'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + lvl_t'(1);
                2'b01:   level_q <= level_q - lvl_t'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between uart_rx and host logic: arms/disarms the
// receiver with graceful shutdown, buffers bytes in a FWFT FIFO, flags
// overrun and line-idle timeout.
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : host receive request (level)
//   flush               : synchronous FIFO clear
//   rd_en/rd_data       : FIFO pop / head byte
//   empty/full/level    : FIFO status
//   overrun, clr_ovr    : sticky dropped-byte flag and its clear
//   idle_to             : one-cycle idle-timeout pulse
//   rx_en               : receiver enable to uart_rx
//   rx_busy/rx_done/rx_data : status and data from uart_rx
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter logic [15:0] TIMEOUT_CYC = RXC_TIMEOUT_CYC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    input  logic                   clr_ovr,
    output logic                   idle_to,
    output logic                   rx_en,
    input  logic                   rx_busy,
    input  logic                   rx_done,
    input  logic [7:0]             rx_data
);

    rxc_state_e  state_q, state_d;
    logic        rx_en_q;
    logic        overrun_q, overrun_d;
    logic [15:0] timer_q, timer_d;
    logic        idle_to_q, idle_to_d;
    logic        drop;

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (rx_done),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

    // When full, rd_en implies a real pop, which makes room for the byte.
    // A flushed write is discarded, not dropped, so it does not flag overrun.
    assign drop = rx_done && full && !rd_en && !flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RXC_DISABLED: begin
                if (enable) state_d = RXC_LISTEN;
            end
            RXC_LISTEN: begin
                if (!enable)     state_d = RXC_DISABLED;
                else if (rx_busy) state_d = RXC_ACTIVE;
            end
            RXC_ACTIVE: begin
                // Frame ended (done) or false start (busy fell without done).
                if (rx_done || !rx_busy) state_d = enable ? RXC_LISTEN : RXC_DISABLED;
                else if (!enable)        state_d = RXC_STOPPING;
            end
            RXC_STOPPING: begin
                if (rx_done || !rx_busy) state_d = RXC_DISABLED;
                else if (enable)         state_d = RXC_ACTIVE;
            end
            default: state_d = RXC_DISABLED;
        endcase
    end

    always_comb begin
        timer_d   = timer_q;
        idle_to_d = 1'b0;
        overrun_d = overrun_q;
        if (rx_done) begin
            timer_d = TIMEOUT_CYC;
        end else if (timer_q != 16'd0 && !rx_busy) begin
            timer_d   = timer_q - 16'd1;
            idle_to_d = (timer_q == 16'd1);
        end
        if (drop)         overrun_d = 1'b1;
        else if (clr_ovr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RXC_DISABLED;
            rx_en_q   <= 1'b0;
            overrun_q <= 1'b0;
            timer_q   <= 16'd0;
            idle_to_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_en_q   <= (state_d == RXC_LISTEN) || (state_d == RXC_ACTIVE);
            overrun_q <= overrun_d;
            timer_q   <= timer_d;
            idle_to_q <= idle_to_d;
        end
    end

    assign rx_en   = rx_en_q;
    assign overrun = overrun_q;
    assign idle_to = idle_to_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic, checked
// against a queue-based reference model and a read-data scoreboard.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int          TOUT  = 10;
    localparam int          MDIS  = 0;
    localparam int          MLIS  = 1;
    localparam int          MACT  = 2;
    localparam int          MSTP  = 3;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       flush;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       overrun;
    logic       clr_ovr;
    logic       idle_to;
    logic       rx_en;
    logic       rx_busy;
    logic       rx_done;
    logic [7:0] rx_data;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] sb_q[$];
    int         m_state;
    bit         m_ovr;
    int         m_timer;
    bit         m_idle;

    uart_rx_ctrl #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (16'(TOUT))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .flush   (flush),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level),
        .overrun (overrun),
        .clr_ovr (clr_ovr),
        .idle_to (idle_to),
        .rx_en   (rx_en),
        .rx_busy (rx_busy),
        .rx_done (rx_done),
        .rx_data (rx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb_q.delete();
        m_state = MDIS;
        m_ovr   = 1'b0;
        m_timer = 0;
        m_idle  = 1'b0;
    endtask

    // One clock of the reference behaviour, from the inputs sampled at the edge.
    task automatic model_step();
        bit do_rd;
        bit drop;
        do_rd  = rd_en && (m_q.size() > 0);
        drop   = rx_done && !flush && (m_q.size() == DEPTH) && !do_rd;
        m_idle = 1'b0;
        if (flush) begin
            m_q.delete();
            sb_q.delete();
        end else begin
            if (do_rd) void'(m_q.pop_front());
            if (rx_done && !drop) begin
                m_q.push_back(rx_data);
                sb_q.push_back(rx_data);
            end
        end
        if (drop)         m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
        if (rx_done) begin
            m_timer = TOUT;
        end else if (m_timer > 0 && !rx_busy) begin
            m_timer--;
            if (m_timer == 0) m_idle = 1'b1;
        end
        case (m_state)
            MDIS: if (enable) m_state = MLIS;
            MLIS: begin
                if (!enable)      m_state = MDIS;
                else if (rx_busy) m_state = MACT;
            end
            MACT: begin
                if (rx_done || !rx_busy) m_state = enable ? MLIS : MDIS;
                else if (!enable)        m_state = MSTP;
            end
            default: begin
                if (rx_done || !rx_busy) m_state = MDIS;
                else if (enable)         m_state = MACT;
            end
        endcase
    endtask

    // Model update and status comparison every clock while out of reset.
    always @(posedge clk) begin
        if (rst) begin
            model_step();
            #1;
            check("level",   32'(level),   32'(m_q.size()));
            check("empty",   32'(empty),   32'(m_q.size() == 0));
            check("full",    32'(full),    32'(m_q.size() == DEPTH));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("idle_to", 32'(idle_to), 32'(m_idle));
            check("rx_en",   32'(rx_en),   32'(m_state == MLIS || m_state == MACT));
        end
    end

    // Scoreboard monitor: each real pop must present the oldest stored byte.
    always @(negedge clk) begin
        if (rst && rd_en && !empty) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_data: got %0h, expected nothing queued (t=%0t)", rd_data, $time);
            end else begin
                check("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_busy = 1'b1;
        repeat (3) tick();
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
        rx_busy = 1'b0;
    endtask

    task automatic drain();
        rd_en = 1'b1;
        repeat (DEPTH + 1) tick();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rd_data"}, 32'(rd_data), 32'h0);
        check({tag, ".empty"},   32'(empty),   32'h1);
        check({tag, ".full"},    32'(full),    32'h0);
        check({tag, ".level"},   32'(level),   32'h0);
        check({tag, ".overrun"}, 32'(overrun), 32'h0);
        check({tag, ".idle_to"}, 32'(idle_to), 32'h0);
        check({tag, ".rx_en"},   32'(rx_en),   32'h0);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; flush = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
        rx_busy = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        model_reset();
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Three bytes then pop them in order.
        enable = 1'b1;
        tick();
        send_byte(8'h55);
        send_byte(8'hA3);
        send_byte(8'h0F);
        check("three.level", 32'(level), 32'd3);
        drain();
        check("three.empty", 32'(empty), 32'h1);

        // Overrun with five bytes and no reads.
        for (int i = 1; i <= 5; i++) send_byte(8'(i * 8'h11));
        check("ovr.full",    32'(full),    32'h1);
        check("ovr.overrun", 32'(overrun), 32'h1);
        drain();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(8'hB0 + i));
        rx_busy = 1'b1;
        repeat (2) tick();
        rx_done = 1'b1; rx_data = 8'hB5; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rx_busy = 1'b0; rd_en = 1'b0;
        check("pop5.overrun", 32'(overrun), 32'h0);
        check("pop5.level",   32'(level),   32'd4);
        drain();

        // Graceful stop: drop enable mid-frame, frame still lands.
        rx_busy = 1'b1;
        repeat (2) tick();
        enable = 1'b0;
        tick();
        check("stop.rx_en", 32'(rx_en), 32'h0);
        tick();
        rx_done = 1'b1; rx_data = 8'h7E;
        tick();
        rx_done = 1'b0; rx_busy = 1'b0;
        check("stop.level", 32'(level), 32'd1);
        tick();
        check("stop.rx_en_off", 32'(rx_en), 32'h0);
        drain();

        // False start.
        enable = 1'b1;
        tick();
        rx_busy = 1'b1;
        repeat (5) tick();
        rx_busy = 1'b0;
        tick();
        check("false.rx_en", 32'(rx_en), 32'h1);
        repeat (12) tick();

        // Idle timeout: plain, then with 4 busy cycles in between.
        send_byte(8'h3C);
        repeat (9) tick();
        check("idle10.early", 32'(idle_to), 32'h0);
        tick();
        check("idle10.pulse", 32'(idle_to), 32'h1);
        tick();
        check("idle10.after", 32'(idle_to), 32'h0);
        send_byte(8'h3D);
        tick();
        rx_busy = 1'b1;
        repeat (4) tick();
        rx_busy = 1'b0;
        repeat (8) tick();
        check("idle14.early", 32'(idle_to), 32'h0);
        tick();
        check("idle14.pulse", 32'(idle_to), 32'h1);
        drain();

        // Flush concurrent with rx_done while overrun is set.
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
        flush = 1'b1; rx_done = 1'b1; rx_data = 8'hEE;
        tick();
        flush = 1'b0; rx_done = 1'b0;
        check("flush.level",   32'(level),   32'd0);
        check("flush.overrun", 32'(overrun), 32'h1);

        // Asynchronous reset mid-frame with two bytes held.
        send_byte(8'h21);
        send_byte(8'h42);
        rx_busy = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async");
        rx_busy = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        send_byte(8'h99);
        check("postrst.level", 32'(level), 32'd1);
        drain();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(49) == 0) enable = ~enable;
            if ($urandom_range(5) == 0)  rx_busy = ~rx_busy;
            rx_done = ($urandom_range(5) == 0);
            rx_data = 8'($urandom);
            rd_en   = ($urandom_range(2) == 0);
            flush   = ($urandom_range(99) == 0);
            clr_ovr = ($urandom_range(29) == 0);
            tick();
        end
        rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_ovr = 1'b0; rx_busy = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sits between `uart_rx` and the host/register logic. It arms and disarms the receiver, buffers received bytes in a small first-word-fall-through FIFO, and flags overrun and line-idle timeout. It also performs a graceful shutdown so that a frame in flight is never cut off when the host disables reception.

## Interface
Parameters:
- `DEPTH`, 4, FIFO depth in bytes; must be a power of 2, range 2..16
- `TIMEOUT_CYC`, 16'd1000, idle clk cycles after the last byte before `idle_to` pulses; must be ≥ 1

Ports:
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  host request to receive (level)
- `flush`  in  1  synchronous FIFO clear (pulse)
- `rd_en`  in  1  pop head byte; ignored when `empty`
- `rd_data`  out  8  FIFO head; valid while `!empty`
- `empty`  out  1  FIFO empty
- `full`  out  1  FIFO full
- `level`  out  $clog2(DEPTH)+1  bytes held
- `overrun`  out  1  sticky; a byte was dropped
- `clr_ovr`  in  1  clears `overrun`
- `idle_to`  out  1  one-cycle idle-timeout pulse
- `rx_en`  out  1  to `uart_rx.rx_en`
- `rx_busy`  in  1  from `uart_rx.busy`
- `rx_done`  in  1  from `uart_rx.done` (one-cycle pulse)
- `rx_data`  in  8  from `uart_rx.d_out`; valid in the `rx_done` cycle

## Operation
- **States:** DISABLED, LISTEN, ACTIVE, STOPPING. Use a 2-bit encoding; unused encodings go to DISABLED.
- **DISABLED:** `rx_en`=0. Go to LISTEN when `enable`=1.
- **LISTEN:** `rx_en`=1.
  - `enable`=0 → DISABLED.
  - `rx_busy`=1 → ACTIVE.
- **ACTIVE:** `rx_en`=1.
  - `rx_done`, or `rx_busy` falling with no `rx_done` (false start) → LISTEN if `enable`, else DISABLED.
  - `enable`=0 while `rx_busy`=1 → STOPPING.
- **STOPPING:** `rx_en`=0. The frame in flight completes.
  - `rx_done` or `!rx_busy` → DISABLED.
  - `enable` re-asserted → ACTIVE.
- **Write:** on every `rx_done`, regardless of state, `rx_data` is written at the tail.
  - If the FIFO is full and there is no simultaneous pop, the byte is dropped and `overrun` is set.
- **Read:** `rd_en` && `!empty` advances the head.
- **Simultaneous write + read:** when full, both succeed, `level` is unchanged and `overrun` is not set. When empty, only the write occurs and `rd_en` is ignored.
- **flush:** `level`:=0, pointers:=0, and any same-cycle write/read is discarded. `overrun` and the state machine are unaffected.
- **clr_ovr:** clears `overrun`. If a drop occurs in the same cycle, set wins.
- **Pointers:** `$clog2(DEPTH)` bits, natural wrap. `level` counts 0..DEPTH.
- **Idle timer:** 16-bit.
  - Loads `TIMEOUT_CYC` on each accepted or dropped byte.
  - Decrements while nonzero and `!rx_busy`.
  - Holds while `rx_busy`=1.
  - The 1→0 transition issues one `idle_to` pulse; the timer then stays at 0 until the next byte.
  - `flush` does not affect the timer.

## Timing
- **Reset values:** state=DISABLED, `rx_en`=0, `rd_data`=0, `empty`=1, `full`=0, `level`=0, `overrun`=0, `idle_to`=0, timer=0.
- **rx_en:** registered; updates one cycle after the state transition that requires it.
- **Write latency:** `rx_done` at edge N → `empty`=0, `level`+1 and `rd_data` valid after edge N+1.
- **Read latency:** `rd_en` sampled at edge N → next head visible after N+1 (FWFT).
- **overrun:** asserted the cycle after the dropped `rx_done`.
- **idle_to:** asserted `TIMEOUT_CYC` cycles after the `rx_done` edge, provided `rx_busy` stays low.
- **Asynchronous reset:** may assert mid-frame; all registers clear immediately, and any later `rx_done` is accepted normally once out of reset.

## Structure
- Shared package `uart_pkg`: state encodings (`RXC_DISABLED`, `RXC_LISTEN`, `RXC_ACTIVE`, `RXC_STOPPING`) and the default `TIMEOUT_CYC`.
- Sub-module `uart_fifo`: a generic FWFT byte FIFO with flush, full, empty and level. It is reusable on the transmit side.
- The controller FSM and idle timer stay in `uart_rx_ctrl`.

## Test plan
- **Receive three bytes:** `enable`=1, then `rx_done` with 0x55, 0xA3, 0x0F → `level`=3; three `rd_en` pops return 0x55, 0xA3, 0x0F in order; `empty`=1.
- **Overrun:** DEPTH=4. Five `rx_done` with no reads → `full`=1, `overrun`=1, and the FIFO holds bytes 1–4. Repeat with `rd_en` coinciding with the 5th `rx_done` → no overrun and the 5th byte is stored.
- **Graceful stop:** drop `enable` while `rx_busy`=1 → `rx_en`=0 next cycle and state=STOPPING. Then `rx_done` with 0x7E → byte stored and state=DISABLED.
- **False start:** `rx_busy` 1 for 5 cycles, then 0 with no `rx_done` → returns to LISTEN; `level` and the timer are unchanged.
- **Idle timeout:** TIMEOUT_CYC=10. One byte, then line idle → a single `idle_to` pulse exactly 10 cycles later. With `rx_busy` held for 4 cycles in between → the pulse arrives at 14 cycles.
- **Reset and flush:**
  - `rst`=0 while ACTIVE with `level`=2 → all outputs at reset values immediately.
  - `flush` concurrent with `rx_done` → `level`=0 and `overrun` is unchanged.
